// File: rtl/byte_unstriping_rx.sv
// Reassembles a byte stream from four skewed lanes, each buffered in its own FIFO and drained round-robin 0->1->2->3.
// Output is registered: one cycle from FIFO head to data_out. Lanes get no back-pressure; writes to a full lane are dropped and flagged.
module byte_unstriping_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             valid_in0,
  input  logic             valid_in1,
  input  logic             valid_in2,
  input  logic             valid_in3,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [3:0]       overflow,
  output logic [3:0]       lane_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] din [4];
  logic [3:0]       vin;
  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [AW-1:0]    wr_ptr [4];
  logic [AW-1:0]    rd_ptr [4];
  logic [AW:0]      count [4];
  logic [1:0]       sel;
  logic             pop;
  logic [3:0]       pop_lane;
  logic [3:0]       full;
  logic [3:0]       wr_en;
  logic [3:0]       drop;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;
  assign vin    = {valid_in3, valid_in2, valid_in1, valid_in0};

  // A full lane still accepts a write when it is being popped in the same cycle.
  always_comb begin
    lane_empty = '0;
    full       = '0;
    pop_lane   = '0;
    wr_en      = '0;
    drop       = '0;
    pop        = 1'b0;
    for (int n = 0; n < 4; n++) begin
      lane_empty[n] = (count[n] == '0);
      full[n]       = (count[n] == (AW+1)'(DEPTH));
    end
    pop = ready & ~lane_empty[sel];
    for (int n = 0; n < 4; n++) begin
      pop_lane[n] = pop && (sel == 2'(n));
      wr_en[n]    = vin[n] & (~full[n] | pop_lane[n]);
      drop[n]     = vin[n] & full[n] & ~pop_lane[n];
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (wr_en[n]) mem[n][wr_ptr[n]] <= din[n];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      sel       <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (wr_en[n])    wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (pop_lane[n]) rd_ptr[n] <= rd_ptr[n] + AW'(1);
        case ({wr_en[n], pop_lane[n]})
          2'b10:   count[n] <= count[n] + (AW+1)'(1);
          2'b01:   count[n] <= count[n] - (AW+1)'(1);
          default: count[n] <= count[n];
        endcase
      end
      overflow <= overflow | drop;
      if (pop) begin
        data_out  <= mem[sel][rd_ptr[sel]];
        valid_out <= 1'b1;
        sel       <= sel + 2'd1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_unstriping_rx.sv
// Bench for byte_unstriping_rx: directed scenarios plus random traffic, compared each cycle against a queue-based stream model.
module tb_byte_unstriping_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
  logic             valid_in0, valid_in1, valid_in2, valid_in3;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [3:0]       overflow;
  logic [3:0]       lane_empty;

  byte_unstriping_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
    .ready(ready), .data_out(data_out), .valid_out(valid_out),
    .overflow(overflow), .lane_empty(lane_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stream model: one queue per lane, a lane pointer and the expected registered outputs.
  logic [WIDTH-1:0] q [4][$];
  int               m_sel;
  logic [3:0]       m_ovf;
  logic [WIDTH-1:0] m_dout;
  logic             m_vout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 4; n++) q[n].delete();
    m_sel  = 0;
    m_ovf  = 4'b0000;
    m_dout = '0;
    m_vout = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] emp;
    for (int n = 0; n < 4; n++) emp[n] = (q[n].size() == 0);
    check({tag, ".valid_out"},  {31'd0, valid_out}, {31'd0, m_vout});
    check({tag, ".data_out"},   {24'd0, data_out},  {24'd0, m_dout});
    check({tag, ".overflow"},   {28'd0, overflow},  {28'd0, m_ovf});
    check({tag, ".lane_empty"}, {28'd0, lane_empty}, {28'd0, emp});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input logic [3:0] v,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input logic r);
    logic [7:0] d [4];
    int popped;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    {valid_in3, valid_in2, valid_in1, valid_in0} = v;
    data_in0 = d0; data_in1 = d1; data_in2 = d2; data_in3 = d3;
    ready = r;
    @(posedge clk);
    popped = -1;
    if (r && q[m_sel].size() > 0) begin
      m_dout = q[m_sel].pop_front();
      m_vout = 1'b1;
      popped = m_sel;
      m_sel  = (m_sel + 1) % 4;
    end else begin
      m_vout = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      if (v[n]) begin
        if (q[n].size() < DEPTH) q[n].push_back(d[n]);
        else m_ovf[n] = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input string tag, input int n, input logic r);
    for (int i = 0; i < n; i++) step(tag, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, r);
  endtask

  initial begin
    reset = 1'b0;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    ready = 1'b0;
    model_clear();
    #12;
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b1;

    // In-order reassembly with all lanes aligned.
    step("inorder", 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    step("inorder", 4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1);
    idle("inorder", 9, 1'b1);

    // Lane 2 lags by three cycles.
    do_reset("reset_skew");
    step("skew", 4'b1011, 8'hC0, 8'hC1, 8'h00, 8'hC3, 1'b1);
    idle("skew", 3, 1'b1);
    step("skew", 4'b0100, 8'h00, 8'h00, 8'hC2, 8'h00, 1'b1);
    idle("skew", 4, 1'b1);

    // Back-pressure: bytes arrive while ready is low, then drain in lane order.
    do_reset("reset_bp");
    step("bp", 4'b0001, 8'hD0, 8'h00, 8'h00, 8'h00, 1'b0);
    step("bp", 4'b0010, 8'h00, 8'hD1, 8'h00, 8'h00, 1'b0);
    step("bp", 4'b0100, 8'h00, 8'h00, 8'hD2, 8'h00, 1'b0);
    step("bp", 4'b1000, 8'h00, 8'h00, 8'h00, 8'hD3, 1'b0);
    idle("bp", 1, 1'b0);
    idle("bp", 5, 1'b1);

    // Overflow on lane 3 with the consumer stalled.
    do_reset("reset_ovf");
    for (int i = 0; i < 5; i++)
      step("ovf", 4'b1000, 8'h00, 8'h00, 8'h00, 8'(8'hE0 + i), 1'b0);
    check("ovf.flag_const", {28'd0, overflow}, 32'h8);
    for (int i = 0; i < 3; i++)
      step("ovf", 4'b0111, 8'(8'hF0 + i), 8'(8'hF4 + i), 8'(8'hF8 + i), 8'h00, 1'b1);
    idle("ovf", 16, 1'b1);
    check("ovf.sticky_const", {28'd0, overflow}, 32'h8);

    // Full lane 0 written while being popped: no overflow.
    do_reset("reset_fullpop");
    for (int i = 0; i < 4; i++)
      step("fullpop", 4'b0001, 8'(8'h50 + i), 8'h00, 8'h00, 8'h00, 1'b0);
    step("fullpop", 4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
    check("fullpop.no_ovf_const", {28'd0, overflow}, 32'h0);
    for (int i = 0; i < 4; i++)
      step("fullpop", 4'b1110, 8'h00, 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i), 1'b1);
    idle("fullpop", 14, 1'b1);

    // Reset mid-stream: two bytes in lane 1 with sel at lane 2.
    do_reset("reset_mid_pre");
    step("mid", 4'b0011, 8'h90, 8'h91, 8'h00, 8'h00, 1'b0);
    step("mid", 4'b0010, 8'h00, 8'h92, 8'h00, 8'h00, 1'b0);
    step("mid", 4'b0010, 8'h00, 8'h93, 8'h00, 8'h00, 1'b0);
    idle("mid", 2, 1'b1);
    do_reset("reset_mid");
    step("mid_after", 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1);
    idle("mid_after", 1, 1'b1);
    check("mid.data_const", {24'd0, data_out}, 32'h11);
    check("mid.valid_const", {31'd0, valid_out}, 32'h1);

    // Random traffic.
    do_reset("reset_rand");
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] v;
      for (int n = 0; n < 4; n++) v[n] = ($urandom_range(0, 3) == 0);
      step("rand", v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    idle("rand_drain", 20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/byte_unstriping_rx.md
# byte_unstriping_rx

Receive-side counterpart of the 4-lane byte striper. It accepts bytes arriving on four parallel lanes, possibly skewed relative to each other, and buffers each lane in its own small FIFO. It reassembles the original serial byte stream by draining the lanes round-robin, lane 0 → 1 → 2 → 3 → 0. It sits between the lane receivers and the byte-wide consumer, and flags per-lane overflow.

## Interface
- WIDTH, 8: byte width of every lane and of the output.
- DEPTH, 4: entries per lane FIFO; a power of 2, ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low.
- data_in0..data_in3  input  WIDTH  lane N byte.
- valid_in0..valid_in3  input  1  lane N byte valid, sampled every rising edge; no back-pressure to lanes.
- ready  input  1  downstream consumer accepts a byte this cycle.
- data_out  output  WIDTH  reassembled byte (registered).
- valid_out  output  1  data_out carries a new byte this cycle (registered).
- overflow  output  4  sticky per-lane overflow flag; bit N = lane N.
- lane_empty  output  4  combinational, bit N = lane N FIFO empty.

## Operation
- Each lane has an independent FIFO with wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits, 0..DEPTH).
- Write: when valid_inN=1 and the FIFO is not full, store data_inN at wr_ptr, then wr_ptr+1 and count+1.
- Write to full FIFO: if the same lane is popped in that same cycle, the write is accepted; count is unchanged. Otherwise the byte is dropped, overflow[N] is set to 1, and pointers do not change.
- overflow bits are cleared only by reset.
- Read selector sel is 2 bits, reset to 0, and points at the lane expected to supply the next byte of the stream.
- Pop condition: ready=1 and lane_empty[sel]=0. On a pop:
  - data_out ← head of FIFO[sel];
  - valid_out ← 1;
  - rd_ptr[sel]+1 and count[sel]−1;
  - sel ← sel+1, wrapping 3 → 0.
- No pop (ready=0 or FIFO[sel] empty): valid_out ← 0, data_out holds its previous value, sel holds. Other lanes are never read out of order, even when they hold data.
- Simultaneous write and pop on the same lane: both take effect. count is unchanged when the FIFO is neither empty nor full.
- Empty FIFO receiving a write: the new byte is not poppable in the same cycle. The read uses registered state only.
- Reset (asynchronous, any time including mid-stream):
  - all pointers and counts → 0;
  - sel → 0;
  - data_out → 0, valid_out → 0, overflow → 4'b0000;
  - lane_empty → 4'b1111.
  - Buffered bytes are discarded.

## Timing
- Latency: a byte sampled on valid_inN at edge t, with sel=N, ready=1 and FIFO[N] previously empty, appears as valid_out=1 after edge t+1 (2 cycles from input to output).
- Throughput: 1 byte per cycle when all lanes keep pace, i.e. 4 bytes per 4 cycles at an aggregate input of 1 byte per lane per 4 cycles.
- Skew tolerance: a lane may lead the slowest lane by up to DEPTH bytes without overflow.
- overflow[N] rises on the edge at which the dropped byte was sampled.
- lane_empty reflects current count and is valid in the same cycle.
- Reset deassertion is synchronous-release by the system; the first write can occur on the first edge with reset=1.

## Test plan
- Reset mid-stream: with 2 bytes in lane 1 and sel=2, assert reset → outputs 0, lane_empty=4'b1111, sel=0. The next valid_in0=1 with 0x11 gives data_out=0x11 two cycles later.
- In-order reassembly: present 0xA0/0xA1/0xA2/0xA3 on lanes 0–3 in the same cycle, then 0xB0–0xB3, with ready=1 → data_out = A0, A1, A2, A3, B0, B1, B2, B3 on consecutive cycles, valid_out=1 each.
- Skew: lane 2 delayed 3 cycles relative to the others → output stalls after lane 1 (valid_out=0) until lane 2's byte arrives, then resumes in order. No overflow.
- Back-pressure: ready=0 for 5 cycles while lanes deliver 1 byte each → valid_out=0 and data_out held throughout. After ready=1, the 4 bytes emerge in lane order.
- Overflow: with ready=0, drive 5 bytes into lane 3 (DEPTH=4) → overflow=4'b1000 after the 5th. Re-enable ready → lane 3 yields only its first 4 bytes, and overflow stays set.
- Full plus pop: with lane 0 full, ready=1 and sel=0, write 0x5A in the same cycle → no overflow, count stays 4, and 0x5A is the 4th byte later popped from lane 0.
